// File: rtl/fdre_pipe.sv
// fdre_pipe: WIDTH-bit, DEPTH-stage stallable register pipeline with per-stage valid,
// preset, flush, a runtime-selectable tap and a registered occupancy count.
module fdre_pipe #(
  parameter int unsigned      WIDTH         = 8,
  parameter int unsigned      DEPTH         = 4,
  parameter logic [WIDTH-1:0] INIT          = {WIDTH{1'b0}},
  parameter logic [WIDTH-1:0] PRE_VALUE     = {WIDTH{1'b1}},
  parameter bit               IS_C_INVERTED = 1'b0,
  parameter logic [WIDTH-1:0] IS_D_INVERTED = {WIDTH{1'b0}},
  localparam int unsigned     SEL_W         = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned     OCC_W         = $clog2(DEPTH + 1)
) (
  input  logic             C,
  input  logic             R,
  input  logic             CE,
  input  logic             PRE,
  input  logic             FLUSH,
  input  logic [WIDTH-1:0] D,
  input  logic             DV,
  input  logic [SEL_W-1:0] TAP_SEL,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic [WIDTH-1:0] TAP,
  output logic             TAPV,
  output logic [OCC_W-1:0] OCC
);

  // Inverting the clock folds into the flop clock polarity on FPGA fabrics.
  logic clk_eff;
  assign clk_eff = C ^ IS_C_INVERTED;

  // Declaration initialisers give the time-0 state without relying on R.
  logic [DEPTH-1:0][WIDTH-1:0] data_q  = {DEPTH{INIT}};
  logic [DEPTH-1:0]            valid_q = '0;
  logic [OCC_W-1:0]            occ_q   = '0;

  logic [DEPTH-1:0][WIDTH-1:0] data_d;
  logic [DEPTH-1:0]            valid_d;
  logic [OCC_W-1:0]            occ_d;

  // Source of each stage on an advance: stage 0 takes the (masked) input.
  logic [DEPTH-1:0][WIDTH-1:0] shift_data;
  logic [DEPTH-1:0]            shift_valid;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign shift_data[gi]  = D ^ IS_D_INVERTED;
        assign shift_valid[gi] = DV;
      end else begin : g_body
        assign shift_data[gi]  = data_q[gi-1];
        assign shift_valid[gi] = valid_q[gi-1];
      end
    end
  endgenerate

  // Priority below reset: PRE > FLUSH > CE > hold.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (PRE) begin
      data_d = {DEPTH{PRE_VALUE}};
    end else if (FLUSH) begin
      valid_d = '0;
    end else if (CE) begin
      data_d  = shift_data;
      valid_d = shift_valid;
    end
  end

  always_comb begin
    occ_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_d = occ_d + OCC_W'(valid_d[i]);
    end
  end

  always_ff @(posedge clk_eff) begin
    if (R) begin
      data_q  <= {DEPTH{INIT}};
      valid_q <= '0;
      occ_q   <= '0;
    end else begin
      data_q  <= data_d;
      valid_q <= valid_d;
      occ_q   <= occ_d;
    end
  end

  // Out-of-range selects (and DEPTH=1) fall through to the last stage.
  always_comb begin
    TAP  = data_q[DEPTH-1];
    TAPV = valid_q[DEPTH-1];
    for (int i = 0; i < DEPTH; i++) begin
      if (TAP_SEL == SEL_W'(i)) begin
        TAP  = data_q[i];
        TAPV = valid_q[i];
      end
    end
  end

  assign Q   = data_q[DEPTH-1];
  assign QV  = valid_q[DEPTH-1];
  assign OCC = occ_q;

endmodule

// File: tb/tb_fdre_pipe.sv
// Directed bench for fdre_pipe: scoreboard on the main pipe's Q stream plus
// direct checks of occupancy, tap, priority, clock inversion and DEPTH=3 taps.
module tb_fdre_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Main instance: WIDTH=8, DEPTH=4, rising edge.
  logic       a_R = 0, a_CE = 0, a_PRE = 0, a_FLUSH = 0, a_DV = 0;
  logic [7:0] a_D = 8'h00;
  logic [1:0] a_SEL = 2'd0;
  logic [7:0] a_Q, a_TAP;
  logic       a_QV, a_TAPV;
  logic [2:0] a_OCC;

  fdre_pipe #(.WIDTH(8), .DEPTH(4)) u_a (
    .C(clk), .R(a_R), .CE(a_CE), .PRE(a_PRE), .FLUSH(a_FLUSH), .D(a_D), .DV(a_DV),
    .TAP_SEL(a_SEL), .Q(a_Q), .QV(a_QV), .TAP(a_TAP), .TAPV(a_TAPV), .OCC(a_OCC)
  );

  // Falling-edge instance with input inversion mask 0x0F.
  logic       b_R = 0, b_CE = 0, b_PRE = 0, b_FLUSH = 0, b_DV = 0;
  logic [7:0] b_D = 8'h00;
  logic [1:0] b_SEL = 2'd0;
  logic [7:0] b_Q, b_TAP;
  logic       b_QV, b_TAPV;
  logic [2:0] b_OCC;

  fdre_pipe #(.WIDTH(8), .DEPTH(4), .IS_C_INVERTED(1'b1), .IS_D_INVERTED(8'h0F)) u_b (
    .C(clk), .R(b_R), .CE(b_CE), .PRE(b_PRE), .FLUSH(b_FLUSH), .D(b_D), .DV(b_DV),
    .TAP_SEL(b_SEL), .Q(b_Q), .QV(b_QV), .TAP(b_TAP), .TAPV(b_TAPV), .OCC(b_OCC)
  );

  // Non-power-of-2 depth instance.
  logic       c_R = 0, c_CE = 0, c_PRE = 0, c_FLUSH = 0, c_DV = 0;
  logic [7:0] c_D = 8'h00;
  logic [1:0] c_SEL = 2'd0;
  logic [7:0] c_Q, c_TAP;
  logic       c_QV, c_TAPV;
  logic [1:0] c_OCC;

  fdre_pipe #(.WIDTH(8), .DEPTH(3)) u_c (
    .C(clk), .R(c_R), .CE(c_CE), .PRE(c_PRE), .FLUSH(c_FLUSH), .D(c_D), .DV(c_DV),
    .TAP_SEL(c_SEL), .Q(c_Q), .QV(c_QV), .TAP(c_TAP), .TAPV(c_TAPV), .OCC(c_OCC)
  );

  logic [7:0] exp_q[$];

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%02h, expected 0x%02h at %0t", nm, act, exp, $time);
    end else begin
      $display("ok   %s: 0x%02h at %0t", nm, act, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Issue one advance on the main pipe; valid data is queued for the monitor.
  task automatic a_adv(input logic [7:0] d, input logic dv);
    a_CE = 1'b1;
    a_DV = dv;
    a_D  = d;
    if (dv) exp_q.push_back(d);
    tick();
  endtask

  // Monitor: each advance edge that leaves a valid word on Q consumes one entry.
  logic       mon_adv;
  logic [7:0] mon_exp;
  initial begin
    forever begin
      @(posedge clk);
      mon_adv = a_CE && !a_R && !a_PRE && !a_FLUSH;
      #1;
      if (mon_adv && a_QV) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got 0x%02h, expected no valid output at %0t", a_Q, $time);
        end else begin
          mon_exp = exp_q.pop_front();
          chk("sb_q", a_Q, mon_exp);
        end
      end
    end
  end

  logic [7:0] tap_exp [4] = '{8'hB2, 8'hB1, 8'hB0, 8'hB0};

  initial begin
    // Time-0 state, before any reset.
    #1;
    chk("t0_a_q", a_Q, 8'h00);
    chk("t0_a_occ", 8'(a_OCC), 8'd0);
    chk("t0_b_qv", 8'(b_QV), 8'd0);
    chk("t0_b_occ", 8'(b_OCC), 8'd0);

    // 1: fill and stream.
    a_R = 1'b1;
    tick();
    a_R = 1'b0;
    chk("rst_q", a_Q, 8'h00);
    chk("rst_qv", 8'(a_QV), 8'd0);
    chk("rst_occ", 8'(a_OCC), 8'd0);
    for (int k = 0; k < 5; k++) begin
      a_adv(8'((k + 1) * 8'h11), 1'b1);
      chk("fill_occ", 8'(a_OCC), (k < 4) ? 8'(k + 1) : 8'd4);
      if (k == 3) chk("lat4_q", a_Q, 8'h11);
      if (k == 4) chk("lat5_q", a_Q, 8'h22);
    end

    // 2: stall.
    a_adv(8'hA0, 1'b1);
    a_adv(8'hA1, 1'b1);
    a_CE  = 1'b0;
    a_SEL = 2'd1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("stall_q", a_Q, 8'h44);
      chk("stall_tap", a_TAP, 8'hA0);
      chk("stall_occ", 8'(a_OCC), 8'd4);
    end
    for (int k = 0; k < 4; k++) begin
      a_adv(8'h00, 1'b0);
      chk("drain_occ", 8'(a_OCC), 8'(3 - k));
      if (k == 1) chk("stall_lat_q", a_Q, 8'hA0);
    end

    // 3: priority PRE over FLUSH over CE.
    a_SEL = 2'd0;
    for (int k = 0; k < 4; k++) a_adv(8'(8'hC0 + k), 1'b1);
    a_PRE = 1'b1; a_FLUSH = 1'b1; a_CE = 1'b1; a_DV = 1'b1; a_D = 8'h77;
    foreach (exp_q[i]) exp_q[i] = 8'hFF;
    tick();
    chk("pre_occ", 8'(a_OCC), 8'd4);
    chk("pre_q", a_Q, 8'hFF);
    chk("pre_qv", 8'(a_QV), 8'd1);
    chk("pre_tap0", a_TAP, 8'hFF);
    a_PRE = 1'b0; a_CE = 1'b0;
    exp_q.delete();
    tick();
    a_FLUSH = 1'b0;
    chk("flush_occ", 8'(a_OCC), 8'd0);
    chk("flush_q", a_Q, 8'hFF);
    chk("flush_qv", 8'(a_QV), 8'd0);

    // 4: reset mid-stream with everything else asserted.
    for (int k = 1; k <= 4; k++) a_adv(8'(k), 1'b1);
    a_R = 1'b1; a_PRE = 1'b1; a_FLUSH = 1'b1; a_CE = 1'b1; a_DV = 1'b1; a_D = 8'h99;
    exp_q.delete();
    tick();
    a_R = 1'b0; a_PRE = 1'b0; a_FLUSH = 1'b0; a_CE = 1'b0;
    chk("mrst_q", a_Q, 8'h00);
    chk("mrst_qv", 8'(a_QV), 8'd0);
    chk("mrst_occ", 8'(a_OCC), 8'd0);
    chk("mrst_tap0", a_TAP, 8'h00);
    tick();
    chk("mrst_hold_occ", 8'(a_OCC), 8'd0);
    for (int k = 0; k < 4; k++) a_adv(8'(8'h5A + k), 1'b1);
    chk("resume_q", a_Q, 8'h5A);
    for (int k = 0; k < 3; k++) a_adv(8'h00, 1'b0);
    a_CE = 1'b0;
    tick();
    chk("sb_empty", 8'(exp_q.size()), 8'd0);

    // 5: falling-edge instance with D inversion.
    b_R = 1'b1;
    @(negedge clk); #1;
    b_R = 1'b0;
    chk("b_rst_occ", 8'(b_OCC), 8'd0);
    b_CE = 1'b1; b_DV = 1'b1; b_D = 8'h3C;
    @(negedge clk); #1;
    chk("b_cap_tap0", b_TAP, 8'h33);
    chk("b_cap_tapv", 8'(b_TAPV), 8'd1);
    chk("b_cap_occ", 8'(b_OCC), 8'd1);
    b_D = 8'h55;
    @(posedge clk); #1;
    chk("b_rise_tap0", b_TAP, 8'h33);
    chk("b_rise_occ", 8'(b_OCC), 8'd1);
    b_CE = 1'b0;
    @(negedge clk); #1;
    chk("b_hold_tap0", b_TAP, 8'h33);
    tick();

    // 6: DEPTH=3 tap sweep and bubble.
    c_R = 1'b1;
    tick();
    c_R = 1'b0; c_CE = 1'b1; c_DV = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c_D = 8'(8'hB0 + k);
      tick();
    end
    c_CE = 1'b0;
    for (int s = 0; s < 4; s++) begin
      c_SEL = 2'(s);
      #1;
      chk("c_tap", c_TAP, tap_exp[s]);
      chk("c_tapv", 8'(c_TAPV), 8'd1);
    end
    chk("c_q", c_Q, 8'hB0);
    chk("c_occ3", 8'(c_OCC), 8'd3);
    c_R = 1'b1;
    tick();
    c_R = 1'b0; c_CE = 1'b1;
    for (int k = 0; k < 3; k++) begin
      c_D  = 8'(8'hB0 + k);
      c_DV = (k != 1);
      tick();
    end
    c_CE = 1'b0;
    c_SEL = 2'd1; #1;
    chk("c_bub_tapv", 8'(c_TAPV), 8'd0);
    chk("c_bub_tap", c_TAP, 8'hB1);
    c_SEL = 2'd0; #1;
    chk("c_bub_tapv0", 8'(c_TAPV), 8'd1);
    c_SEL = 2'd3; #1;
    chk("c_oor_tapv", 8'(c_TAPV), 8'd1);
    chk("c_bub_occ", 8'(c_OCC), 8'd2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
